// File: rtl/fb_pkg.sv
// Shared framebuffer constants and type definitions for the VRAM write path.
package fb_pkg;

  // Framebuffer geometry and bus widths
  localparam int FB_W    = 200;
  localparam int FB_H    = 150;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int ADDR_W  = 15;
  localparam int RGB_W   = 12;

  // Arbiter top-level state: waiting for work, or sweeping the fill colour
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Who owned the VRAM write port on the most recent granted cycle
  typedef enum logic {
    GNT_PAINT = 1'b0,
    GNT_CLR   = 1'b1
  } gnt_t;

endpackage

// File: rtl/fb_sweep_cnt.sv
// Ascending pixel address counter for the full-screen fill sweep.
// Loads zero at sweep start, advances once per issued fill write and
// parks on the terminal address instead of wrapping.
module fb_sweep_cnt
  import fb_pkg::*;
#(
  parameter int TERMINAL = FB_SIZE - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_zero,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] TC_VAL = ADDR_W'(TERMINAL);

  assign tc = (count == TC_VAL);

  // Counter register: restart takes priority, otherwise step until terminal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load_zero) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fb_write_arb.sv
// VRAM write-port arbiter: shares one registered write port between a
// paint requester (valid/ready) and a full-screen fill sweep. While a
// fill is running the port alternates between fill and paint whenever
// paint is pending, so neither side can be starved.
module fb_write_arb
  import fb_pkg::ADDR_W, fb_pkg::RGB_W, fb_pkg::state_t, fb_pkg::gnt_t,
         fb_pkg::IDLE, fb_pkg::CLEAR, fb_pkg::GNT_PAINT, fb_pkg::GNT_CLR;
#(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  input  logic [RGB_W-1:0]  clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              p_valid,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [RGB_W-1:0]  p_data,
  output logic              p_ready,
  output logic [ADDR_W-1:0] waddr,
  output logic [RGB_W-1:0]  wdata,
  output logic              we
);

  localparam int FB_SIZE = FB_W * FB_H;
  localparam logic [ADDR_W:0] SIZE_V = (ADDR_W + 1)'(FB_SIZE);

  state_t             state;
  state_t             state_next;
  gnt_t               last_gnt;
  logic [RGB_W-1:0]   fill_color;
  logic [ADDR_W-1:0]  sweep_addr;
  logic               sweep_last;
  logic               paint_xfer;
  logic               paint_in_range;
  logic               fill_issue;
  logic               sweep_load;

  fb_sweep_cnt #(
    .TERMINAL (FB_SIZE - 1)
  ) u_sweep (
    .clk       (clk),
    .rst       (rst),
    .load_zero (sweep_load),
    .en        (fill_issue),
    .count     (sweep_addr),
    .tc        (sweep_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: start on request when idle, leave after the last fill write
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_start) state_next = CLEAR;
      CLEAR:   if (fill_issue && sweep_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant decode: paint readiness depends only on registered state, never on p_valid
  always_comb begin
    p_ready        = (state == IDLE) || (last_gnt == GNT_CLR);
    paint_xfer     = p_valid && p_ready;
    fill_issue     = (state == CLEAR) && !paint_xfer;
    sweep_load     = (state == IDLE) && clr_start;
    paint_in_range = ({1'b0, p_addr} < SIZE_V);
  end

  // Remember who used the port last so the next contended cycle goes to the other side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= GNT_PAINT;
    end else if (paint_xfer) begin
      last_gnt <= GNT_PAINT;
    end else if (fill_issue) begin
      last_gnt <= GNT_CLR;
    end
  end

  // Fill colour is captured only when a sweep actually starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_color <= '0;
    end else if (sweep_load) begin
      fill_color <= clr_color;
    end
  end

  // Registered write port; out-of-range paint is consumed but never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (paint_xfer) begin
      we <= paint_in_range;
      if (paint_in_range) begin
        waddr <= p_addr;
        wdata <= p_data;
      end
    end else if (fill_issue) begin
      we    <= 1'b1;
      waddr <= sweep_addr;
      wdata <= fill_color;
    end else begin
      we <= 1'b0;
    end
  end

  // Status flags aligned with the write port timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_done <= 1'b0;
      clr_busy <= 1'b0;
    end else begin
      clr_done <= fill_issue && sweep_last;
      clr_busy <= (state == CLEAR);
    end
  end

endmodule

// File: tb/tb_fb_write_arb.sv
// Self-checking bench for fb_write_arb: directed phases with randomized
// paint traffic, compared cycle by cycle with a rule-level reference model.
module tb_fb_write_arb;
  import fb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr_start;
  logic [RGB_W-1:0]  clr_color;
  logic              clr_busy;
  logic              clr_done;
  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [RGB_W-1:0]  p_data;
  logic              p_ready;
  logic [ADDR_W-1:0] waddr;
  logic [RGB_W-1:0]  wdata;
  logic              we;

  int checks = 0;
  int errors = 0;

  // Reference model: sweep progress and expected port contents
  bit                m_sweeping;
  bit                m_sweeping_prev;
  bit                m_fill_last;
  int                m_next;
  logic [RGB_W-1:0]  m_color;
  bit                m_took;
  bit                e_we;
  bit                e_done;
  logic [ADDR_W-1:0] e_waddr;
  logic [RGB_W-1:0]  e_wdata;

  // Observations of the DUT taken at each stimulus step
  bit obs_we;
  bit obs_done;
  bit obs_hs;

  always #5 clk = ~clk;

  fb_write_arb dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .p_valid   (p_valid),
    .p_addr    (p_addr),
    .p_data    (p_data),
    .p_ready   (p_ready),
    .waddr     (waddr),
    .wdata     (wdata),
    .we        (we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_sweeping      = 1'b0;
    m_sweeping_prev = 1'b0;
    m_fill_last     = 1'b0;
    m_next          = 0;
    m_color         = '0;
    m_took          = 1'b0;
    e_we            = 1'b0;
    e_done          = 1'b0;
    e_waddr         = '0;
    e_wdata         = '0;
  endtask

  // One clock of spec behaviour: paint wins unless the fill is owed a turn
  task automatic modelStep(input bit v, input logic [ADDR_W-1:0] a, input logic [RGB_W-1:0] d,
                           input bit cs, input logic [RGB_W-1:0] cc);
    bit was_sweeping;
    bit ready;
    was_sweeping    = m_sweeping;
    ready           = !m_sweeping || m_fill_last;
    m_sweeping_prev = m_sweeping;
    e_done          = 1'b0;
    m_took          = 1'b0;
    if (v && ready) begin
      m_took      = 1'b1;
      m_fill_last = 1'b0;
      if (int'(a) < FB_SIZE) begin
        e_we    = 1'b1;
        e_waddr = a;
        e_wdata = d;
      end else begin
        e_we = 1'b0;
      end
    end else if (m_sweeping) begin
      e_we        = 1'b1;
      e_waddr     = ADDR_W'(m_next);
      e_wdata     = m_color;
      m_fill_last = 1'b1;
      if (m_next == FB_SIZE - 1) begin
        e_done     = 1'b1;
        m_sweeping = 1'b0;
      end else begin
        m_next++;
      end
    end else begin
      e_we = 1'b0;
    end
    if (!was_sweeping && cs) begin
      m_color    = cc;
      m_next     = 0;
      m_sweeping = 1'b1;
    end
  endtask

  task automatic checkOutput();
    chk("we", 32'(we), 32'(e_we));
    chk("waddr", 32'(waddr), 32'(e_waddr));
    chk("wdata", 32'(wdata), 32'(e_wdata));
    chk("clr_done", 32'(clr_done), 32'(e_done));
    chk("p_ready", 32'(p_ready), 32'(!m_sweeping || m_fill_last));
    if (m_sweeping == m_sweeping_prev) chk("clr_busy", 32'(clr_busy), 32'(m_sweeping));
  endtask

  // Check the previous cycle, then drive the next one and advance the model
  task automatic applyStimulus(input bit v, input logic [ADDR_W-1:0] a, input logic [RGB_W-1:0] d,
                               input bit cs, input logic [RGB_W-1:0] cc);
    @(negedge clk);
    checkOutput();
    obs_we    = we;
    obs_done  = clr_done;
    p_valid   = v;
    p_addr    = a;
    p_data    = d;
    clr_start = cs;
    clr_color = cc;
    obs_hs    = p_valid && p_ready;
    modelStep(v, a, d, cs, cc);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nwe;
    int ndone;
    int hs_dut;
    int hs_model;
    logic [ADDR_W-1:0] ra;
    logic [RGB_W-1:0]  rd;

    rst       = 1'b1;
    clr_start = 1'b0;
    clr_color = '0;
    p_valid   = 1'b0;
    p_addr    = '0;
    p_data    = '0;
    modelReset();

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput();
    chk("reset_busy", 32'(clr_busy), 32'd0);
    rst = 1'b0;

    // Full fill with no paint traffic
    $display("[TB] fill without paint");
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h0A5);
    nwe = 0;
    ndone = 0;
    for (int i = 0; i < 30100; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      if (obs_we) nwe++;
      if (obs_done) begin
        ndone++;
        break;
      end
    end
    chk("fill_we_count", 32'(nwe), 32'd30000);
    chk("fill_done_count", 32'(ndone), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    chk("busy_after_fill", 32'(clr_busy), 32'd0);

    // Idle paint write appears one cycle later
    $display("[TB] idle paint");
    applyStimulus(1'b1, 15'd15100, 12'hF00, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    chk("idle_paint_we", 32'(we), 32'd1);
    chk("idle_paint_addr", 32'(waddr), 32'd15100);
    chk("idle_paint_data", 32'(wdata), 32'hF00);

    // Out-of-range paint is accepted and dropped
    applyStimulus(1'b1, 15'd30000, 12'h123, 1'b0, '0);
    chk("oob_ready", 32'(obs_hs), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    chk("oob_we", 32'(we), 32'd0);
    chk("oob_addr_hold", 32'(waddr), 32'd15100);

    // Contention: paint always pending, late clr_start with a new colour
    $display("[TB] contention");
    applyStimulus(1'b0, '0, '0, 1'b1, 12'h3C7);
    hs_dut = 0;
    hs_model = 0;
    for (int i = 0; i < 4000; i++) begin
      ra = ADDR_W'($urandom_range(0, 32767));
      rd = RGB_W'($urandom);
      applyStimulus(1'b1, ra, rd, (i == 100), 12'hFFF);
      chk("alternate", 32'(obs_hs), 32'(i & 1));
      hs_dut += int'(obs_hs);
      hs_model += int'(m_took);
    end
    chk("contention_acks", 32'(hs_dut), 32'(hs_model));
    ndone = 0;
    for (int i = 0; i < 40000; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      if (obs_done) begin
        ndone++;
        break;
      end
    end
    chk("contention_done", 32'(ndone), 32'd1);

    // Simultaneous clr_start and paint, then reset partway through the sweep
    $display("[TB] simultaneous start and mid-fill reset");
    ra = ADDR_W'($urandom_range(0, FB_SIZE - 1));
    rd = RGB_W'($urandom);
    applyStimulus(1'b1, ra, rd, 1'b1, 12'h5A5);
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    chk("sim_paint_addr", 32'(waddr), 32'(ra));
    chk("sim_paint_data", 32'(wdata), 32'(rd));
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    chk("sim_fill0_we", 32'(we), 32'd1);
    chk("sim_fill0_addr", 32'(waddr), 32'd0);
    chk("sim_fill0_data", 32'(wdata), 32'h5A5);
    for (int i = 0; i < 3000; i++) begin
      if (e_we && e_waddr == 15'd1234) break;
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
    end
    @(negedge clk);
    checkOutput();
    chk("pre_reset_addr", 32'(waddr), 32'd1234);
    rst = 1'b1;
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    chk("rst_ready", 32'(p_ready), 32'd1);
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0);
      if (obs_done) ndone++;
    end
    chk("no_done_after_reset", 32'(ndone), 32'd0);

    // Random idle paint traffic
    for (int i = 0; i < 200; i++) begin
      ra = ADDR_W'($urandom_range(0, 32767));
      rd = RGB_W'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), ra, rd, 1'b0, '0);
    end
    @(negedge clk);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_write_arb.md
FB_WRITE_ARB -- requirements
Module: fb_write_arb

Interface
REQ-001 Parameter FB_W, 200, framebuffer width in pixels.
REQ-002 Parameter FB_H, 150, framebuffer height in pixels.
REQ-003 Parameter FB_SIZE, FB_W*FB_H = 30000, number of addressable pixels.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 clr_start  input  1  one-cycle pulse requesting a full-screen fill.
REQ-007 clr_color  input  12  fill colour (RGB444), sampled with clr_start.
REQ-008 clr_busy  output  1  high while the fill sweep is in progress.
REQ-009 clr_done  output  1  one-cycle pulse marking the final fill write.
REQ-010 p_valid  input  1  paint requester has a pixel write pending.
REQ-011 p_addr  input  15  paint pixel address (row*FB_W + col).
REQ-012 p_data  input  12  paint pixel colour.
REQ-013 p_ready  output  1  arbiter accepts the paint write this cycle.
REQ-014 waddr  output  15  VRAM write address, registered.
REQ-015 wdata  output  12  VRAM write data, registered.
REQ-016 we  output  1  VRAM write enable, registered.

Function
REQ-017 FSM SHALL have states IDLE and CLEAR; register last_gnt in {PAINT, CLR}.
REQ-018 Paint handshake: a transfer occurs on a rising edge where p_valid && p_ready; p_ready SHALL NOT depend on p_valid.
REQ-019 p_ready = (state==IDLE) || (state==CLEAR && last_gnt==CLR).
REQ-020 Accepted paint write SHALL appear on we/waddr/wdata one cycle after acceptance (latency 1); last_gnt <= PAINT.
REQ-021 Accepted paint with p_addr >= FB_SIZE SHALL be consumed and dropped (we=0 that cycle).
REQ-022 In CLEAR, any cycle without a paint transfer SHALL issue a fill write of sweep counter address with latched colour, increment counter, last_gnt <= CLR.
REQ-023 Result: fill and paint alternate when both pending; fill advances every cycle when p_valid=0; fill duration 30000 to 60000 cycles.
REQ-024 IDLE and clr_start=1: latch clr_color, counter <= 0, state <= CLEAR; first fill write is issued on the following cycle.
REQ-025 clr_start together with p_valid in IDLE: paint SHALL be accepted that cycle and the fill starts next cycle (no loss).
REQ-026 clr_start while state==CLEAR SHALL be ignored (colour and counter unchanged).
REQ-027 Sweep counter 15 bits, ascending 0..FB_SIZE-1, no wrap; fill write of FB_SIZE-1 SHALL return state to IDLE.
REQ-028 clr_done SHALL be registered and high exactly in the cycle the FB_SIZE-1 fill write is on we/waddr.
REQ-029 clr_busy SHALL equal (state==CLEAR), registered.
REQ-030 we SHALL be 0 in any cycle with no write issued; waddr/wdata hold last value.

Reset
REQ-031 On rst: state IDLE, last_gnt PAINT, counter 0, latched colour 0, waddr 0, wdata 0, we 0, clr_busy 0, clr_done 0.
REQ-032 Reset mid-sweep SHALL abort the fill with no clr_done; a new clr_start is required after release.

Structure
REQ-033 Shared package fb_pkg SHALL hold FB_W, FB_H, FB_SIZE, ADDR_W=15, RGB_W=12 and the state enum {IDLE, CLEAR}.
REQ-034 One sub-module fb_sweep_cnt (load-zero, enable, terminal-count flag at FB_SIZE-1) SHALL implement the sweep counter.

Verification
REQ-035 Idle paint: p_valid=1, p_addr=15100, p_data=12'hF00 -> next cycle we=1, waddr=15100, wdata=12'hF00.
REQ-036 Fill without paint: clr_start, clr_color=12'h0A5 -> 30000 consecutive we with waddr 0..29999, wdata 12'h0A5, clr_done on waddr 29999, clr_busy low next cycle.
REQ-037 Contention: p_valid held 1 during CLEAR -> strict alternation fill/paint on we; sweep completes in 60000 cycles, every paint ack'd once.
REQ-038 Boundary: paint p_addr=30000 accepted -> p_ready=1, we=0 next cycle; clr_start during CLEAR with new colour -> colour unchanged.
REQ-039 Simultaneous: clr_start+p_valid in IDLE -> paint write first, fill waddr=0 on following cycle.
REQ-040 Reset mid-fill at waddr 1234 -> all outputs 0 asynchronously, no clr_done, FSM IDLE, p_ready=1.
